// File: rtl/systolic_feed_ctrl_2x2.sv
// systolic_feed_ctrl_2x2
//   Drive-side controller for a 2x2 systolic array. It accepts an operand pair
//   (A, B) of 2x2 FP32 matrices, pulses the array clear, streams the diagonally
//   skewed row/column beats, waits for the array pipeline to settle, then
//   captures the four array outputs and offers C = A*B to the consumer.
//   Element values are carried as opaque bit patterns and never interpreted.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only while idle)
//   a_mat, b_mat        {x00,x01,x10,x11}, x00 in the MSBs
//   arr_clr             one-cycle clear pulse to the array
//   W0, W1              row inputs to the array
//   N0, N1              column inputs to the array
//   out0_0..out1_1      array result outputs
//   res_valid/res_ready result handshake
//   c_mat               {c00,c01,c10,c11}, c00 in the MSBs
//   busy                high whenever a transaction is in flight

`timescale 1ns/1ps

module systolic_feed_ctrl_2x2 #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] a_mat,
    input  logic [4*DATA_W-1:0] b_mat,
    output logic                arr_clr,
    output logic [DATA_W-1:0]   W0,
    output logic [DATA_W-1:0]   W1,
    output logic [DATA_W-1:0]   N0,
    output logic [DATA_W-1:0]   N1,
    input  logic [DATA_W-1:0]   out0_0,
    input  logic [DATA_W-1:0]   out0_1,
    input  logic [DATA_W-1:0]   out1_0,
    input  logic [DATA_W-1:0]   out1_1,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [4*DATA_W-1:0] c_mat,
    output logic                busy
);

    // The drain counter runs 0..DRAIN_CYCLES; the final count is the capture cycle.
    localparam int               CNT_W      = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic [4*DATA_W-1:0]   r_aMat;
    logic [4*DATA_W-1:0]   r_bMat;
    logic [1:0]            r_beat;
    logic [CNT_W-1:0]      r_drainCnt;
    logic                  r_inReady;
    logic                  r_arrClr;
    logic [DATA_W-1:0]     r_w0;
    logic [DATA_W-1:0]     r_w1;
    logic [DATA_W-1:0]     r_n0;
    logic [DATA_W-1:0]     r_n1;
    logic                  r_resValid;
    logic [4*DATA_W-1:0]   r_cMat;
    logic                  r_busy;

    logic [DATA_W-1:0]     w_a00, w_a01, w_a10, w_a11;
    logic [DATA_W-1:0]     w_b00, w_b01, w_b10, w_b11;

    assign w_a00 = r_aMat[4*DATA_W-1 -: DATA_W];
    assign w_a01 = r_aMat[3*DATA_W-1 -: DATA_W];
    assign w_a10 = r_aMat[2*DATA_W-1 -: DATA_W];
    assign w_a11 = r_aMat[DATA_W-1:0];
    assign w_b00 = r_bMat[4*DATA_W-1 -: DATA_W];
    assign w_b01 = r_bMat[3*DATA_W-1 -: DATA_W];
    assign w_b10 = r_bMat[2*DATA_W-1 -: DATA_W];
    assign w_b11 = r_bMat[DATA_W-1:0];

    assign in_ready  = r_inReady;
    assign arr_clr   = r_arrClr;
    assign W0        = r_w0;
    assign W1        = r_w1;
    assign N0        = r_n0;
    assign N1        = r_n1;
    assign res_valid = r_resValid;
    assign c_mat     = r_cMat;
    assign busy      = r_busy;

    // Single FSM with every output registered. Each state computes the values the
    // outputs must carry during the *next* cycle, so the beat table appears on the
    // array ports one clock per beat with no combinational path from the inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_aMat     <= '0;
            r_bMat     <= '0;
            r_beat     <= 2'd0;
            r_drainCnt <= '0;
            r_inReady  <= 1'b1;
            r_arrClr   <= 1'b0;
            r_w0       <= '0;
            r_w1       <= '0;
            r_n0       <= '0;
            r_n1       <= '0;
            r_resValid <= 1'b0;
            r_cMat     <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_aMat    <= a_mat;
                        r_bMat    <= b_mat;
                        r_inReady <= 1'b0;
                        r_busy    <= 1'b1;
                        r_arrClr  <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    // Beat 0: only the corner PE receives data.
                    r_arrClr <= 1'b0;
                    r_w0     <= w_a00;
                    r_w1     <= '0;
                    r_n0     <= w_b00;
                    r_n1     <= '0;
                    r_beat   <= 2'd0;
                    r_state  <= S_FEED;
                end

                S_FEED: begin
                    // r_beat names the beat currently on the outputs.
                    case (r_beat)
                        2'd0: begin
                            r_w0   <= w_a01;
                            r_w1   <= w_a10;
                            r_n0   <= w_b10;
                            r_n1   <= w_b01;
                            r_beat <= 2'd1;
                        end
                        2'd1: begin
                            r_w0   <= '0;
                            r_w1   <= w_a11;
                            r_n0   <= '0;
                            r_n1   <= w_b11;
                            r_beat <= 2'd2;
                        end
                        default: begin
                            r_w0       <= '0;
                            r_w1       <= '0;
                            r_n0       <= '0;
                            r_n1       <= '0;
                            r_beat     <= 2'd0;
                            r_drainCnt <= '0;
                            r_state    <= S_DRAIN;
                        end
                    endcase
                end

                S_DRAIN: begin
                    // DRAIN_CYCLES settle cycles followed by the capture cycle.
                    if (r_drainCnt == DRAIN_LAST) begin
                        r_cMat     <= {out0_0, out0_1, out1_0, out1_1};
                        r_resValid <= 1'b1;
                        r_state    <= S_HOLD;
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (res_ready) begin
                        r_resValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_inReady  <= 1'b1;
                    r_arrClr   <= 1'b0;
                    r_resValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
